// File: rtl/axi_to_mem_rw_sched_pkg.sv
// ----------------------------------------------------------------------------
// axi_to_mem_sched_pkg
// Shared types for the axi_to_mem read/write memory-port scheduler.
//   state_e    : scheduler FSM state (IDLE, RD, WR)
//   dir_e      : transfer direction (DIR_RD = 0, DIR_WR = 1)
//   beat_cnt_t : beat counter for the default 8-bit AXI length field
//                (one extra bit so len = 2^LenWidth-1 cannot overflow)
// ----------------------------------------------------------------------------
package axi_to_mem_sched_pkg;

    localparam int unsigned DefLenWidth = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_e;

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } dir_e;

    typedef logic [DefLenWidth:0] beat_cnt_t;

endpackage

// File: rtl/axi_to_mem_rw_sched_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin picker between the read and write paths. When both
// request, the direction that did not win last time is picked. The
// last-grant register only moves on an update strobe (end of a grant
// window) and is left untouched by a flush.
// Ports:
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   flush_i          : suppresses any last-grant update this cycle
//   req_rd_i/req_wr_i: requests from the read / write path
//   update_i         : grant window finished; record upd_dir_i as last grant
//   upd_dir_i        : direction whose window just finished
//   gnt_valid_o      : at least one side requests
//   gnt_dir_o        : picked direction (meaningful when gnt_valid_o is high)
// ----------------------------------------------------------------------------
module rr_arb2
    import axi_to_mem_sched_pkg::*;
#(
    parameter logic FirstPrio = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic req_rd_i,
    input  logic req_wr_i,
    input  logic update_i,
    input  dir_e upd_dir_i,
    output logic gnt_valid_o,
    output dir_e gnt_dir_o
);

    dir_e last_q;

    always_comb begin
        gnt_valid_o = req_rd_i | req_wr_i;
        if (req_rd_i && req_wr_i) begin
            gnt_dir_o = (last_q == DIR_RD) ? DIR_WR : DIR_RD;
        end else if (req_wr_i) begin
            gnt_dir_o = DIR_WR;
        end else begin
            gnt_dir_o = DIR_RD;
        end
    end

    // Reset to the opposite of FirstPrio so the first contention favours it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= dir_e'(~FirstPrio);
        end else if (update_i && !flush_i) begin
            last_q <= upd_dir_i;
        end
    end

endmodule

// File: rtl/axi_to_mem_rw_sched.sv
// ----------------------------------------------------------------------------
// axi_to_mem_rw_sched
// Shares one single-ported memory request interface between the read path
// and the write path of axi_to_mem. A whole burst is granted at a time;
// beats are counted against the burst length and the paths alternate
// round-robin at burst boundaries. The first beat is presented in the same
// cycle the arbitration decision is made; one idle cycle separates bursts.
//
// Optional feature (macro ARB_BURST_SPLIT_EN): a grant window is limited to
// MaxChunk beats when the other side is waiting; the interrupted burst keeps
// its remaining count and resumes later without re-sampling its length.
//
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   flush_i                : synchronous abort back to IDLE
//   rd_valid_i/rd_len_i    : read beat pending / read burst length
//   rd_ready_o             : read beat accepted this cycle
//   wr_valid_i/wr_len_i    : write beat pending / write burst length
//   wr_ready_o             : write beat accepted this cycle
//   mem_req_o/mem_we_o     : memory request / write enable
//   mem_gnt_i              : memory accepts the request
//   wr_last_o              : accepted write beat is the last of its burst
//   busy_o                 : scheduler is inside a burst
// ----------------------------------------------------------------------------
module axi_to_mem_rw_sched #(
    parameter int unsigned LenWidth  = 8,
    parameter logic        FirstPrio = 1'b0,
    parameter int unsigned MaxChunk  = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                rd_valid_i,
    input  logic [LenWidth-1:0] rd_len_i,
    output logic                rd_ready_o,
    input  logic                wr_valid_i,
    input  logic [LenWidth-1:0] wr_len_i,
    output logic                wr_ready_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    input  logic                mem_gnt_i,
    output logic                wr_last_o,
    output logic                busy_o
);
    import axi_to_mem_sched_pkg::*;

    if (MaxChunk < 1) begin : g_bad_maxchunk
        $error("MaxChunk must be at least 1");
    end

    typedef logic [LenWidth:0] cnt_t;

    state_e state_q;
    cnt_t   cnt_q;
    logic   gap_q;      // forces the idle cycle that follows a grant window

    logic   arb_valid;
    dir_e   arb_dir;
    dir_e   cur_dir;
    logic   sel_valid;
    cnt_t   len_ext;
    cnt_t   cnt_start;
    cnt_t   cnt_cur;
    logic   beat_done;
    logic   last_beat;
    logic   suspend;
    logic   window_end;

    rr_arb2 #(
        .FirstPrio (FirstPrio)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .req_rd_i    (rd_valid_i),
        .req_wr_i    (wr_valid_i),
        .update_i    (window_end),
        .upd_dir_i   (cur_dir),
        .gnt_valid_o (arb_valid),
        .gnt_dir_o   (arb_dir)
    );

    // In IDLE the arbiter's pick drives the port directly (zero latency);
    // inside a burst only the owning side can request.
    always_comb begin
        cur_dir   = arb_dir;
        sel_valid = 1'b0;
        case (state_q)
            RD: begin
                cur_dir   = DIR_RD;
                sel_valid = rd_valid_i;
            end
            WR: begin
                cur_dir   = DIR_WR;
                sel_valid = wr_valid_i;
            end
            default: begin
                cur_dir   = arb_dir;
                sel_valid = arb_valid & ~gap_q;
            end
        endcase
    end

    assign len_ext    = {1'b0, (cur_dir == DIR_WR) ? wr_len_i : rd_len_i};
    assign cnt_cur    = (state_q == IDLE) ? cnt_start : cnt_q;
    assign last_beat  = (cnt_cur == '0);

    assign mem_req_o  = sel_valid & ~flush_i;
    assign mem_we_o   = mem_req_o & (cur_dir == DIR_WR);
    assign beat_done  = mem_req_o & mem_gnt_i;
    assign rd_ready_o = beat_done & (cur_dir == DIR_RD);
    assign wr_ready_o = beat_done & (cur_dir == DIR_WR);
    assign wr_last_o  = wr_ready_o & last_beat;
    assign busy_o     = (state_q != IDLE) & ~flush_i;
    assign window_end = beat_done & (last_beat | suspend);

`ifdef ARB_BURST_SPLIT_EN
    localparam int unsigned ChunkW = $clog2(MaxChunk) + 1;
    typedef logic [ChunkW-1:0] chunk_t;

    chunk_t     chunk_q;
    chunk_t     chunk_cur;
    chunk_t     chunk_nxt;
    cnt_t       save_q [2];
    logic [1:0] pend_q;
    logic       other_valid;

    // The chunk count saturates at MaxChunk so an exhausted window yields on
    // the first beat completed after the other side turns up.
    assign chunk_cur   = (state_q == IDLE) ? '0 : chunk_q;
    assign chunk_nxt   = (chunk_cur == chunk_t'(MaxChunk)) ? chunk_cur
                                                           : chunk_cur + chunk_t'(1);
    assign other_valid = (cur_dir == DIR_RD) ? wr_valid_i : rd_valid_i;
    assign suspend     = beat_done & ~last_beat & other_valid
                         & (chunk_nxt == chunk_t'(MaxChunk));
    assign cnt_start   = pend_q[cur_dir] ? save_q[cur_dir] : len_ext;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chunk_q   <= '0;
            pend_q    <= '0;
            save_q[0] <= '0;
            save_q[1] <= '0;
        end else if (flush_i) begin
            chunk_q <= '0;
            pend_q  <= '0;
        end else if (beat_done) begin
            if (state_q == IDLE) begin
                pend_q[cur_dir] <= 1'b0;
            end
            if (suspend) begin
                pend_q[cur_dir] <= 1'b1;
                save_q[cur_dir] <= cnt_cur - cnt_t'(1);
                chunk_q         <= '0;
            end else if (last_beat) begin
                chunk_q <= '0;
            end else begin
                chunk_q <= chunk_nxt;
            end
        end
    end
`else
    assign suspend   = 1'b0;
    assign cnt_start = len_ext;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= 1'b0;
        end else if (flush_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= 1'b0;
        end else if (beat_done) begin
            if (last_beat || suspend) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                gap_q   <= 1'b1;
            end else begin
                state_q <= (cur_dir == DIR_WR) ? WR : RD;
                cnt_q   <= cnt_cur - cnt_t'(1);
            end
        end else if (state_q == IDLE) begin
            gap_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_to_mem_rw_sched.sv
// ----------------------------------------------------------------------------
// tb_axi_to_mem_rw_sched
// Bench for axi_to_mem_rw_sched. Each cycle's expected outputs are packed as
// {mem_req, mem_we, rd_ready, wr_ready, wr_last, busy}.
// ----------------------------------------------------------------------------
module tb_axi_to_mem_rw_sched;

`ifdef ARB_BURST_SPLIT_EN
    localparam int unsigned TbMaxChunk = 4;
`else
    localparam int unsigned TbMaxChunk = 16;
`endif

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       rd_valid;
    logic [7:0] rd_len;
    logic       rd_ready;
    logic       wr_valid;
    logic [7:0] wr_len;
    logic       wr_ready;
    logic       mem_req;
    logic       mem_we;
    logic       mem_gnt;
    logic       wr_last;
    logic       busy;
    logic [5:0] obs;

    int n_chk  = 0;
    int n_fail = 0;
    logic [5:0] sb [$];

    axi_to_mem_rw_sched #(
        .LenWidth  (8),
        .FirstPrio (1'b0),
        .MaxChunk  (TbMaxChunk)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .rd_valid_i (rd_valid),
        .rd_len_i   (rd_len),
        .rd_ready_o (rd_ready),
        .wr_valid_i (wr_valid),
        .wr_len_i   (wr_len),
        .wr_ready_o (wr_ready),
        .mem_req_o  (mem_req),
        .mem_we_o   (mem_we),
        .mem_gnt_i  (mem_gnt),
        .wr_last_o  (wr_last),
        .busy_o     (busy)
    );

    assign obs = {mem_req, mem_we, rd_ready, wr_ready, wr_last, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0; mem_gnt = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0;
        mem_gnt = 1'b1; rd_len = 8'd3; wr_len = 8'd3;
        @(negedge clk);
        n_chk++;
        if (obs !== 6'b000000) begin
            n_fail++; $display("FAIL reset_in: observed %b expected %b", obs, 6'b000000);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (obs !== 6'b000000) begin
            n_fail++; $display("FAIL reset_out: observed %b expected %b", obs, 6'b000000);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_read_burst();
        logic [5:0] want;
        for (int c = 0; c < 4; c++) sb.push_back(c == 0 ? 6'b101000 : 6'b101001);
        sb.push_back(6'b000000);
        sb.push_back(6'b000000);
        for (int c = 0; c < 6; c++) begin
            rd_valid = (c < 5); rd_len = 8'd3; wr_valid = 1'b0; mem_gnt = 1'b1;
            @(negedge clk);
            want = sb.pop_front();
            n_chk++;
            if (obs !== want) begin
                n_fail++; $display("FAIL read_burst c%0d: observed %b expected %b", c, obs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_contention();
        logic [5:0] want;
        logic [5:0] tab [10];
        do_reset();
        tab = '{6'b101000, 6'b101001, 6'b000000, 6'b110100, 6'b110111,
                6'b000000, 6'b101000, 6'b101001, 6'b000000, 6'b000000};
        for (int c = 0; c < 10; c++) sb.push_back(tab[c]);
        for (int c = 0; c < 10; c++) begin
            rd_valid = (c < 9); wr_valid = (c < 9);
            rd_len = 8'd1; wr_len = 8'd1; mem_gnt = 1'b1;
            @(negedge clk);
            want = sb.pop_front();
            n_chk++;
            if (obs !== want) begin
                n_fail++; $display("FAIL contention c%0d: observed %b expected %b", c, obs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] want;
        logic [5:0] tab [8];
        logic       gnt_pat [8];
        tab = '{6'b110100, 6'b110001, 6'b110101, 6'b110001,
                6'b110111, 6'b000000, 6'b101000, 6'b000000};
        gnt_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int c = 0; c < 8; c++) sb.push_back(tab[c]);
        for (int c = 0; c < 8; c++) begin
            wr_valid = (c < 5); wr_len = 8'd2;
            rd_valid = (c >= 1 && c < 7); rd_len = 8'd0;
            mem_gnt = gnt_pat[c];
            @(negedge clk);
            want = sb.pop_front();
            n_chk++;
            if (obs !== want) begin
                n_fail++; $display("FAIL backpressure c%0d: observed %b expected %b", c, obs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_boundaries();
        logic [5:0] want;
        sb.push_back(6'b110110);
        sb.push_back(6'b000000);
        for (int c = 0; c < 2; c++) begin
            wr_valid = (c == 0); wr_len = 8'd0; rd_valid = 1'b0; mem_gnt = 1'b1;
            @(negedge clk);
            want = sb.pop_front();
            n_chk++;
            if (obs !== want) begin
                n_fail++; $display("FAIL len0 c%0d: observed %b expected %b", c, obs, want);
            end
            @(posedge clk); #1;
        end
        for (int c = 0; c < 259; c++) begin
            if (c == 0)        sb.push_back(6'b110100);
            else if (c < 255)  sb.push_back(6'b110101);
            else if (c == 255) sb.push_back(6'b110111);
            else if (c == 257) sb.push_back(6'b110110);
            else               sb.push_back(6'b000000);
        end
        for (int c = 0; c < 259; c++) begin
            wr_valid = (c < 258); wr_len = (c < 257) ? 8'd255 : 8'd0;
            rd_valid = 1'b0; mem_gnt = 1'b1;
            @(negedge clk);
            want = sb.pop_front();
            n_chk++;
            if (obs !== want) begin
                n_fail++; $display("FAIL len255 c%0d: observed %b expected %b", c, obs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        logic [5:0] want;
        logic [5:0] tab [6];
        tab = '{6'b101000, 6'b000000, 6'b101000, 6'b000000, 6'b110110, 6'b000000};
        for (int c = 0; c < 6; c++) sb.push_back(tab[c]);
        for (int c = 0; c < 6; c++) begin
            flush = (c == 1);
            rd_valid = (c < 5); rd_len = (c < 2) ? 8'd7 : 8'd0;
            wr_valid = (c >= 2 && c < 5); wr_len = 8'd0;
            mem_gnt = 1'b1;
            @(negedge clk);
            want = sb.pop_front();
            n_chk++;
            if (obs !== want) begin
                n_fail++; $display("FAIL flush c%0d: observed %b expected %b", c, obs, want);
            end
            @(posedge clk); #1;
        end
        flush = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [5:0] want;
        sb.push_back(6'b110100);
        sb.push_back(6'b110101);
        for (int c = 0; c < 2; c++) begin
            wr_valid = 1'b1; wr_len = 8'd3; rd_valid = 1'b0; mem_gnt = 1'b1;
            @(negedge clk);
            want = sb.pop_front();
            n_chk++;
            if (obs !== want) begin
                n_fail++; $display("FAIL async_pre c%0d: observed %b expected %b", c, obs, want);
            end
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (obs !== 6'b000000) begin
            n_fail++; $display("FAIL async_in: observed %b expected %b", obs, 6'b000000);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        sb.push_back(6'b101000);
        sb.push_back(6'b000000);
        sb.push_back(6'b000000);
        for (int c = 0; c < 3; c++) begin
            rd_valid = (c < 2); wr_valid = (c < 2);
            rd_len = 8'd0; wr_len = 8'd0; mem_gnt = 1'b1;
            @(negedge clk);
            want = sb.pop_front();
            n_chk++;
            if (obs !== want) begin
                n_fail++; $display("FAIL async_post c%0d: observed %b expected %b", c, obs, want);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef ARB_BURST_SPLIT_EN
    task automatic test_split();
        logic [5:0] want;
        logic [5:0] tab [15];
        do_reset();
        tab = '{6'b101000, 6'b101001, 6'b101001, 6'b101001, 6'b000000,
                6'b110100, 6'b110111, 6'b000000, 6'b101000, 6'b101001,
                6'b101001, 6'b101001, 6'b101001, 6'b101001, 6'b000000};
        for (int c = 0; c < 15; c++) sb.push_back(tab[c]);
        for (int c = 0; c < 15; c++) begin
            rd_valid = (c < 14); rd_len = (c < 8) ? 8'd9 : 8'd0;
            wr_valid = (c < 7); wr_len = 8'd1; mem_gnt = 1'b1;
            @(negedge clk);
            want = sb.pop_front();
            n_chk++;
            if (obs !== want) begin
                n_fail++; $display("FAIL split c%0d: observed %b expected %b", c, obs, want);
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; flush = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0;
        rd_len = '0; wr_len = '0; mem_gnt = 1'b0;
        test_reset();
        test_read_burst();
        test_contention();
        test_backpressure();
        test_boundaries();
        test_flush();
        test_async_reset();
`ifdef ARB_BURST_SPLIT_EN
        test_split();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
